// File: rtl/time_pkg.sv
// Shared constants and types for the timer datapath counters.
// Also holds the width helper used to size value and prescaler ports.
package time_pkg;

    localparam int SEC_PER_MIN  = 60;
    localparam int MIN_PER_HOUR = 60;
    localparam int HOUR_PER_DAY = 24;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int count_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider: counts qualified ticks 0..PRESCALE-1.
// Flags the tick that wraps it as a step.
module tick_prescaler
    import time_pkg::*;
#(
    parameter int  PRESCALE = 60,
    localparam int PW       = count_width(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          tick,
    output logic [PW-1:0] pre_o,
    output logic          step
);

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre_o <= '0;
        end else if (tick) begin
            pre_o <= (pre_o == PRE_LAST) ? '0 : pre_o + 1'b1;
        end
    end

    // Not masked by clr; the parent gives clear/load priority over the step.
    assign step = tick && (pre_o == PRE_LAST);

endmodule

// File: rtl/time_counter.sv
// Cascadable modulo time counter with prescaler, up/down, preset/clear and
// optional saturation. carry_o feeds tick_i of the next stage.
module time_counter
    import time_pkg::*;
#(
    parameter int  PRESCALE = 60,
    parameter int  MODULO   = 24,
    parameter int  WRAP     = 1,
    localparam int W        = count_width(MODULO),
    localparam int PW       = count_width(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_i,
    input  logic          en_i,
    input  logic          dir_i,
    input  logic          load_i,
    input  logic [W-1:0]  load_val_i,
    input  logic          clr_i,
    output logic [W-1:0]  value_o,
    output logic [PW-1:0] pre_o,
    output logic          carry_o,
    output logic          sat_o
);

    localparam logic [W-1:0] VAL_LAST = W'(MODULO - 1);
    localparam logic [W:0]   MOD_EXT  = (W + 1)'(MODULO);

    dir_e         dir;
    logic         qtick;
    logic         step;
    logic         at_terminal;
    logic [W-1:0] load_clamped;
    logic [W-1:0] value_d;
    logic         carry_d;

    assign dir          = dir_e'(dir_i);
    assign qtick        = tick_i && en_i;
    assign at_terminal  = (dir == DIR_DOWN) ? (value_o == '0) : (value_o == VAL_LAST);
    assign sat_o        = at_terminal;
    assign load_clamped = ({1'b0, load_val_i} >= MOD_EXT) ? VAL_LAST : load_val_i;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_i || load_i),
        .tick (qtick),
        .pre_o(pre_o),
        .step (step)
    );

    // Terminal count is tested before stepping so the value never leaves 0..MODULO-1.
    always_comb begin
        value_d = value_o;
        carry_d = 1'b0;
        if (step) begin
            if (!at_terminal) begin
                value_d = (dir == DIR_DOWN) ? value_o - 1'b1 : value_o + 1'b1;
            end else if (WRAP != 0) begin
                value_d = (dir == DIR_DOWN) ? VAL_LAST : '0;
                carry_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            value_o <= '0;
            carry_o <= 1'b0;
        end else if (load_i) begin
            value_o <= load_clamped;
            carry_o <= 1'b0;
        end else begin
            value_o <= value_d;
            carry_o <= carry_d;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: vector table on a wrapping 60/24 counter,
// plus hand sequences for the saturating variant and a minute/hour cascade.
module tb_time_counter;
    import time_pkg::*;

    localparam int NVEC = 21;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       en;
        logic       dir;
        logic       load;
        logic       clr;
        logic [4:0] loadVal;
        int         cycles;
        int         expValue;
        int         expPre;
        logic       expCarry;
        logic       expSat;
        int         expCarries;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, tick, en, dir, load, clr;
    logic [4:0] loadVal;
    logic [4:0] value, wValue;
    logic [5:0] pre, wPre;
    logic       carry, sat, wCarry, wSat;

    logic       ctick, hLoad;
    logic [4:0] hVal;
    logic [5:0] minValue, minPre;
    logic       minCarry, minSat;
    logic [4:0] hourValue;
    logic [0:0] hourPre;
    logic       hourCarry, hourSat;

    int total = 0;
    int bad = 0;
    int carryCount = 0;
    int wCarryCount = 0;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    time_counter #(.PRESCALE(SEC_PER_MIN), .MODULO(HOUR_PER_DAY), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .en_i(en), .dir_i(dir),
        .load_i(load), .load_val_i(loadVal), .clr_i(clr),
        .value_o(value), .pre_o(pre), .carry_o(carry), .sat_o(sat)
    );

    time_counter #(.PRESCALE(SEC_PER_MIN), .MODULO(HOUR_PER_DAY), .WRAP(0)) dutSat (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .en_i(en), .dir_i(dir),
        .load_i(load), .load_val_i(loadVal), .clr_i(clr),
        .value_o(wValue), .pre_o(wPre), .carry_o(wCarry), .sat_o(wSat)
    );

    time_counter #(.PRESCALE(SEC_PER_MIN), .MODULO(MIN_PER_HOUR), .WRAP(1)) minStage (
        .clk(clk), .rst_n(rst_n), .tick_i(ctick), .en_i(1'b1), .dir_i(1'b0),
        .load_i(1'b0), .load_val_i(6'd0), .clr_i(1'b0),
        .value_o(minValue), .pre_o(minPre), .carry_o(minCarry), .sat_o(minSat)
    );

    time_counter #(.PRESCALE(1), .MODULO(HOUR_PER_DAY), .WRAP(1)) hourStage (
        .clk(clk), .rst_n(rst_n), .tick_i(minCarry), .en_i(1'b1), .dir_i(1'b0),
        .load_i(hLoad), .load_val_i(hVal), .clr_i(1'b0),
        .value_o(hourValue), .pre_o(hourPre), .carry_o(hourCarry), .sat_o(hourSat)
    );

    // Carry pulses are counted just after each edge so a vector can check how many it produced.
    always @(posedge clk) begin
        #1;
        if (carry === 1'b1) carryCount++;
        if (wCarry === 1'b1) wCarryCount++;
    end

    function automatic vec_t mkVec(input logic r, t, e, d, l, c, input int lv, input int cyc,
                                   input int ev, input int ep, input logic ec, input logic es,
                                   input int n);
        vec_t v;
        v.rst = r; v.tick = t; v.en = e; v.dir = d; v.load = l; v.clr = c;
        v.loadVal = 5'(lv); v.cycles = cyc; v.expValue = ev; v.expPre = ep;
        v.expCarry = ec; v.expSat = es; v.expCarries = n;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveFor(input logic r, t, e, d, l, c, input logic [4:0] lv, input int cycles);
        rst_n = r; tick = t; en = e; dir = d; load = l; clr = c; loadVal = lv;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int startCount;
        startCount = carryCount;
        driveFor(v.rst, v.tick, v.en, v.dir, v.load, v.clr, v.loadVal, v.cycles);
        checkOutput($sformatf("vec%0d value", idx), 32'(value), 32'(v.expValue));
        checkOutput($sformatf("vec%0d pre", idx), 32'(pre), 32'(v.expPre));
        checkOutput($sformatf("vec%0d carry", idx), 32'(carry), 32'(v.expCarry));
        checkOutput($sformatf("vec%0d sat", idx), 32'(sat), 32'(v.expSat));
        checkOutput($sformatf("vec%0d carries", idx), 32'(carryCount - startCount), 32'(v.expCarries));
    endtask

    // Runs n second ticks into the cascade and one idle cycle, noting edge indices of events.
    task automatic runCascade(input int n, output int tMin, output int tHour, output int tHourCarry,
                              output int nMin, output int nHourCarry);
        logic [4:0] prevHour;
        tMin = -1; tHour = -1; tHourCarry = -1; nMin = 0; nHourCarry = 0;
        prevHour = hourValue;
        ctick = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i == n - 1) ctick = 1'b0;
            if (minCarry === 1'b1) begin nMin++; tMin = i; end
            if (hourCarry === 1'b1) begin nHourCarry++; tHourCarry = i; end
            if (hourValue !== prevHour && tHour < 0) tHour = i;
            prevHour = hourValue;
        end
        @(negedge clk);
    endtask

    initial begin
        int tMin, tHour, tHourCarry, nMin, nHourCarry, wStart;
        rst_n = 1'b0; tick = 1'b0; en = 1'b1; dir = 1'b0; load = 1'b0; clr = 1'b0;
        loadVal = '0; ctick = 1'b0; hLoad = 1'b0; hVal = '0;

        //                r     t     e     d     l     c     lv  cyc  val pre carry sat   n
        vecs[0]  = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  2,    0,  0, 1'b0, 1'b0, 0);
        vecs[1]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  59,   0, 59, 1'b0, 1'b0, 0);
        vecs[2]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1,    1,  0, 1'b0, 1'b0, 0);
        vecs[3]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1380, 0,  0, 1'b1, 1'b0, 1);
        vecs[4]  = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1,    0,  0, 1'b0, 1'b0, 0);
        vecs[5]  = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 23, 1,   23,  0, 1'b0, 1'b1, 0);
        vecs[6]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  60,   0,  0, 1'b1, 1'b0, 1);
        vecs[7]  = mkVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30, 1,   23,  0, 1'b0, 1'b1, 0);
        vecs[8]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  59,  23, 59, 1'b0, 1'b1, 0);
        vecs[9]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 23, 1,   23,  0, 1'b0, 1'b1, 0);
        vecs[10] = mkVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0,  1,    0,  0, 1'b0, 1'b1, 0);
        vecs[11] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  60,  23,  0, 1'b1, 1'b0, 1);
        vecs[12] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  30,  23, 30, 1'b0, 1'b0, 0);
        vecs[13] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  30,   0,  0, 1'b1, 1'b0, 1);
        vecs[14] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7,  1,    0,  0, 1'b0, 1'b0, 0);
        vecs[15] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  25,   0, 25, 1'b0, 1'b0, 0);
        vecs[16] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  100,  0, 25, 1'b0, 1'b0, 0);
        vecs[17] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  35,   1,  0, 1'b0, 1'b0, 0);
        vecs[18] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  60,   0,  0, 1'b0, 1'b1, 0);
        vecs[19] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  10,   0, 10, 1'b0, 1'b0, 0);
        vecs[20] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1,    0,  0, 1'b0, 1'b0, 0);

        @(negedge clk);
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Saturating instance: parked at 0 counting down, then at 23 counting up.
        driveFor(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1);
        checkOutput("sat clr value", 32'(wValue), 32'd0);
        checkOutput("sat clr sat", 32'(wSat), 32'd1);
        wStart = wCarryCount;
        driveFor(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 120);
        checkOutput("sat down value", 32'(wValue), 32'd0);
        checkOutput("sat down pre", 32'(wPre), 32'd0);
        checkOutput("sat down sat", 32'(wSat), 32'd1);
        checkOutput("sat down carries", 32'(wCarryCount - wStart), 32'd0);
        driveFor(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 60);
        checkOutput("sat release value", 32'(wValue), 32'd1);
        checkOutput("sat release sat", 32'(wSat), 32'd0);
        driveFor(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 1);
        checkOutput("sat load value", 32'(wValue), 32'd23);
        checkOutput("sat load sat", 32'(wSat), 32'd1);
        wStart = wCarryCount;
        driveFor(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 60);
        checkOutput("sat up value", 32'(wValue), 32'd23);
        checkOutput("sat up pre", 32'(wPre), 32'd0);
        checkOutput("sat up carries", 32'(wCarryCount - wStart), 32'd0);
        driveFor(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1);
        checkOutput("sat dir flip sat", 32'(wSat), 32'd0);

        // Cascade: one hour of seconds, then the day roll-over from hour 23.
        runCascade(3600, tMin, tHour, tHourCarry, nMin, nHourCarry);
        checkOutput("casc min carry edge", 32'(tMin), 32'd3599);
        checkOutput("casc min carries", 32'(nMin), 32'd1);
        checkOutput("casc hour step edge", 32'(tHour), 32'd3600);
        checkOutput("casc hour carries", 32'(nHourCarry), 32'd0);
        checkOutput("casc hour value", 32'(hourValue), 32'd1);
        checkOutput("casc min value", 32'(minValue), 32'd0);
        checkOutput("casc min pre", 32'(minPre), 32'd0);
        checkOutput("casc min sat", 32'(minSat), 32'd0);
        checkOutput("casc hour pre", 32'(hourPre), 32'd0);
        hLoad = 1'b1; hVal = 5'd23;
        @(posedge clk);
        @(negedge clk);
        hLoad = 1'b0;
        checkOutput("casc hour preset", 32'(hourValue), 32'd23);
        runCascade(3600, tMin, tHour, tHourCarry, nMin, nHourCarry);
        checkOutput("casc day min edge", 32'(tMin), 32'd3599);
        checkOutput("casc day carry edge", 32'(tHourCarry), 32'd3600);
        checkOutput("casc day carries", 32'(nHourCarry), 32'd1);
        checkOutput("casc day hour value", 32'(hourValue), 32'd0);
        checkOutput("casc day hour sat", 32'(hourSat), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
